// File: rtl/muldiv_unit_pkg.sv
// Shared definitions for the multiply/divide unit: operation codes, FSM state
// encoding and small op-decoding helpers.
package muldiv_unit_pkg;

    typedef enum logic [1:0] {
        OP_MULT  = 2'b00,
        OP_MULTU = 2'b01,
        OP_DIV   = 2'b10,
        OP_DIVU  = 2'b11
    } op_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_MUL  = 2'b01,
        ST_DIV  = 2'b10,
        ST_FIX  = 2'b11
    } state_t;

    function automatic logic op_is_signed(op_t op);
        return ~op[0];
    endfunction

    function automatic logic op_is_div(op_t op);
        return op[1];
    endfunction

endpackage

// File: rtl/muldiv_unit_if.sv
// Request/result bundle between a requester (master) and the multiply/divide unit (slave).
interface muldiv_unit_if
    import muldiv_unit_pkg::*;
#(
    parameter int WIDTH = 32
);
    logic             ena;
    logic             start;
    op_t              op;
    logic [WIDTH-1:0] opr1;
    logic [WIDTH-1:0] opr2;
    logic             flush;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             div_by_zero;

    modport master (
        output ena, start, op, opr1, opr2, flush,
        input  busy, done, hi, lo, div_by_zero
    );

    modport slave (
        input  ena, start, op, opr1, opr2, flush,
        output busy, done, hi, lo, div_by_zero
    );
endinterface

// File: rtl/muldiv_div_step.sv
// One restoring-division iteration: trial-subtract the divisor from the shifted
// partial remainder and keep the difference only when it does not go negative.
module muldiv_div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH:0]   rem_in,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_out,
    output logic             q_bit
);

    assign q_bit = (rem_in >= {1'b0, divisor});

    // When the subtraction succeeds the true result is below the divisor,
    // so modulo-2^WIDTH arithmetic on the low bits is exact.
    assign rem_out = q_bit ? (rem_in[WIDTH-1:0] - divisor) : rem_in[WIDTH-1:0];

endmodule

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit: shift-add multiplier, restoring divider and a
// sign-fix cycle. Divide support is built only when MULDIV_DIV_EN is defined.
module muldiv_unit
    import muldiv_unit_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int MUL_STEP = 1
) (
    input  logic         clk,
    input  logic         reset,
    muldiv_unit_if.slave bus
);

    localparam int                 CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0]   MUL_LAST = CNT_W'(WIDTH / MUL_STEP - 1);

    state_t               state;
    logic [CNT_W-1:0]     count;
    logic                 sign_a;
    logic                 sign_b;
    logic [WIDTH-1:0]     mag_a;
    logic [2*WIDTH-1:0]   acc;
    logic [WIDTH-1:0]     hi_q;
    logic [WIDTH-1:0]     lo_q;
    logic                 done_q;

    logic                 opr1_neg;
    logic                 opr2_neg;
    logic [WIDTH-1:0]     opr1_mag;
    logic [WIDTH-1:0]     opr2_mag;
    logic [WIDTH+MUL_STEP-1:0] mul_sum;
    logic [2*WIDTH-1:0]   mul_next;
    logic [2*WIDTH-1:0]   prod_fix;

    assign opr1_neg = op_is_signed(bus.op) & bus.opr1[WIDTH-1];
    assign opr2_neg = op_is_signed(bus.op) & bus.opr2[WIDTH-1];
    assign opr1_mag = opr1_neg ? -bus.opr1 : bus.opr1;
    assign opr2_mag = opr2_neg ? -bus.opr2 : bus.opr2;

    // acc holds {partial product, unretired multiplier bits}; each step adds
    // multiples of the multiplicand for MUL_STEP bits and shifts them out.
    always_comb begin
        mul_sum = {{MUL_STEP{1'b0}}, acc[2*WIDTH-1:WIDTH]};
        for (int k = 0; k < MUL_STEP; k++) begin
            if (acc[k]) begin
                mul_sum = mul_sum + ({{MUL_STEP{1'b0}}, mag_a} << k);
            end
        end
        mul_next = {mul_sum, acc[WIDTH-1:MUL_STEP]};
    end

    assign prod_fix = (sign_a ^ sign_b) ? -acc : acc;

`ifdef MULDIV_DIV_EN
    logic               is_div;
    logic [WIDTH-1:0]   divisor;
    logic [WIDTH-1:0]   rem_out;
    logic               q_bit;
    logic [2*WIDTH-1:0] div_next;
    logic               dbz_q;

    // For division acc holds {partial remainder, dividend bits / quotient bits}.
    muldiv_div_step #(.WIDTH(WIDTH)) u_div_step (
        .rem_in  ({acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]}),
        .divisor (divisor),
        .rem_out (rem_out),
        .q_bit   (q_bit)
    );

    assign div_next        = {rem_out, acc[WIDTH-2:0], q_bit};
    assign bus.div_by_zero = dbz_q;
`else
    assign bus.div_by_zero = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            state  <= ST_IDLE;
            count  <= '0;
            sign_a <= 1'b0;
            sign_b <= 1'b0;
            mag_a  <= '0;
            acc    <= '0;
            hi_q   <= '0;
            lo_q   <= '0;
            done_q <= 1'b0;
`ifdef MULDIV_DIV_EN
            is_div  <= 1'b0;
            divisor <= '0;
            dbz_q   <= 1'b0;
`endif
        end else if (bus.ena) begin
            done_q <= 1'b0;
`ifdef MULDIV_DIV_EN
            dbz_q  <= 1'b0;
`endif
            if (bus.flush) begin
                state <= ST_IDLE;
                count <= '0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (bus.start) begin
                            count  <= '0;
                            sign_a <= opr1_neg;
                            sign_b <= opr2_neg;
                            mag_a  <= opr1_mag;
                            if (!op_is_div(bus.op)) begin
                                acc   <= {{WIDTH{1'b0}}, opr2_mag};
                                state <= ST_MUL;
`ifdef MULDIV_DIV_EN
                                is_div <= 1'b0;
                            end else begin
                                acc     <= {{WIDTH{1'b0}}, opr1_mag};
                                divisor <= opr2_mag;
                                is_div  <= 1'b1;
                                state   <= ST_DIV;
                            end
`else
                            end else begin
                                done_q <= 1'b1;
                            end
`endif
                        end
                    end
                    ST_MUL: begin
                        acc <= mul_next;
                        if (count == MUL_LAST) begin
                            state <= ST_FIX;
                        end else begin
                            count <= count + 1'b1;
                        end
                    end
`ifdef MULDIV_DIV_EN
                    ST_DIV: begin
                        acc <= div_next;
                        if (count == CNT_W'(WIDTH - 1)) begin
                            state <= ST_FIX;
                        end else begin
                            count <= count + 1'b1;
                        end
                    end
`endif
                    ST_FIX: begin
                        state  <= ST_IDLE;
                        count  <= '0;
                        done_q <= 1'b1;
`ifdef MULDIV_DIV_EN
                        if (is_div) begin
                            // Divide by zero reports the original dividend, not its magnitude.
                            if (divisor == '0) begin
                                lo_q  <= '1;
                                hi_q  <= sign_a ? -mag_a : mag_a;
                                dbz_q <= 1'b1;
                            end else begin
                                lo_q <= (sign_a ^ sign_b) ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
                                hi_q <= sign_a ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
                            end
                        end else begin
                            {hi_q, lo_q} <= prod_fix;
                        end
`else
                        {hi_q, lo_q} <= prod_fix;
`endif
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

    assign bus.busy = (state != ST_IDLE);
    assign bus.done = done_q;
    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;

endmodule
